// File: rtl/matsub4_seq.sv
// matsub4_seq: element-serial f = a - b - c - d over a ROWS x COLS matrix with one shared subtractor.
// Define MATSUB4_SAT_EN to saturate each element; otherwise results wrap modulo 2^WIDTH.
module matsub4_seq #(
  parameter int WIDTH = 16,
  parameter int ROWS = 1,
  parameter int COLS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] a,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] b,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] c,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] d,
  output logic busy,
  output logic done,
  output logic [ROWS:1][COLS:1][WIDTH-1:0] f
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] R_ONE = RW'(1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [ROWS:1][COLS:1][WIDTH-1:0] ra, rb, rc, rd;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] res;
  function automatic logic [WIDTH+1:0] ext(input logic [WIDTH-1:0] x);
    return {{2{x[WIDTH-1]}}, x};
  endfunction
  // Two guard bits hold a - b - c - d exactly for any WIDTH-bit operands.
  always_comb diff = ext(ra[row][col]) - ext(rb[row][col]) - ext(rc[row][col]) - ext(rd[row][col]);
`ifdef MATSUB4_SAT_EN
  logic fits;
  always_comb fits = (diff[WIDTH+1:WIDTH-1] == 3'b000) || (diff[WIDTH+1:WIDTH-1] == 3'b111);
  always_comb res = fits ? diff[WIDTH-1:0] :
                    diff[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  logic unused_hi;
  always_comb unused_hi = ^diff[WIDTH+1:WIDTH];
  always_comb res = diff[WIDTH-1:0];
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      f <= '0;
      row <= R_ONE;
      col <= C_ONE;
      ra <= '0;
      rb <= '0;
      rc <= '0;
      rd <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= b;
          rc <= c;
          rd <= d;
          row <= R_ONE;
          col <= C_ONE;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          f[row][col] <= res;
          if (col == C_LAST) begin
            col <= C_ONE;
            if (row == R_LAST) begin
              row <= R_ONE;
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end else row <= row + R_ONE;
          end else col <= col + C_ONE;
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matsub4_seq.sv
// tb_matsub4_seq: randomized self-checking bench for matsub4_seq against an integer reference model.
module tb_matsub4_seq;
  localparam int W = 16, R = 2, C = 3, P = R * C;
  typedef logic [R:1][C:1][W-1:0] mat_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  mat_t a = '0, b = '0, c = '0, d = '0, f;
  logic busy, done;
  int tests = 0, fails = 0;
  matsub4_seq #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .f(f)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_el(input logic [W-1:0] x, y, z, w);
    int s;
    s = int'($signed(x)) - int'($signed(y)) - int'($signed(z)) - int'($signed(w));
`ifdef MATSUB4_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return W'(s);
  endfunction
  function automatic mat_t ref_mat(input mat_t x, y, z, w);
    mat_t m;
    for (int r = 1; r <= R; r++)
      for (int k = 1; k <= C; k++) m[r][k] = ref_el(x[r][k], y[r][k], z[r][k], w[r][k]);
    return m;
  endfunction
  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 1; r <= R; r++)
      for (int k = 1; k <= C; k++) m[r][k] = W'($urandom);
    return m;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input mat_t x, y, z, w, input bit poke);
    mat_t e, prev;
    e = ref_mat(x, y, z, w);
    prev = f;
    a = x; b = y; c = z; d = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < P; k++) begin
      check("busy_run", 128'(busy), 128'(1));
      check("done_early", 128'(done), 128'(0));
      if (poke && k == 1) begin
        a = {P{16'h7777}};
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      prev[k / C + 1][k % C + 1] = e[k / C + 1][k % C + 1];
      check("f_partial", 128'(f), 128'(prev));
    end
    check("done_pulse", 128'(done), 128'(1));
    check("busy_in_done", 128'(busy), 128'(0));
    check("f_final", 128'(f), 128'(e));
    tick();
    check("done_one_cycle", 128'(done), 128'(0));
    check("busy_idle", 128'(busy), 128'(0));
  endtask
  initial begin
    mat_t x, y, z, w, e;
    int last, nd;
    tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_f", 128'(f), 128'(0));
    reset = 1'b0;
    tick();
    x = rand_mat(); y = rand_mat(); z = rand_mat(); w = rand_mat();
    x[1][1] = 16'h0005; y[1][1] = 16'h0001; z[1][1] = 16'h0002; w[1][1] = 16'h0003;
    x[1][2] = 16'h8000; y[1][2] = 16'h0001; z[1][2] = 16'h0001; w[1][2] = 16'h0001;
    x[1][3] = 16'h7FFF; y[1][3] = 16'hFFFF; z[1][3] = 16'hFFFF; w[1][3] = 16'hFFFF;
    run(x, y, z, w, 1'b1);
`ifdef MATSUB4_SAT_EN
    check("ovf_neg", 128'(f[1][2]), 128'(16'h8000));
    check("ovf_pos", 128'(f[1][3]), 128'(16'h7FFF));
`else
    check("ovf_neg", 128'(f[1][2]), 128'(16'h7FFD));
    check("ovf_pos", 128'(f[1][3]), 128'(16'h8002));
`endif
    check("basic_el", 128'(f[1][1]), 128'(16'hFFFF));
    for (int r = 1; r <= R; r++)
      for (int k = 1; k <= C; k++) x[r][k] = W'(16 * r + k);
    run(x, '0, '0, '0, 1'b0);
    check("order_f_eq_a", 128'(f), 128'(x));
    for (int i = 0; i < 12; i++) run(rand_mat(), rand_mat(), rand_mat(), rand_mat(), i[0]);
    a = rand_mat(); b = rand_mat(); c = rand_mat(); d = rand_mat();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_f", 128'(f), 128'(0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < P + 3; i++) begin
      tick();
      check("abort_no_done", 128'(done), 128'(0));
    end
    run(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 1'b0);
    x = rand_mat(); y = rand_mat(); z = rand_mat(); w = rand_mat();
    e = ref_mat(x, y, z, w);
    a = x; b = y; c = z; d = w;
    start = 1'b1;
    last = -1;
    nd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        nd++;
        check("b2b_f", 128'(f), 128'(e));
        if (last >= 0) check("b2b_period", 128'(i - last), 128'(P + 2));
        last = i;
      end
    end
    start = 1'b0;
    check("b2b_count", 128'(nd), 128'(5));
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
